// File: rtl/traffic_pkg.sv
// Shared codes for the intersection: light colours, phase encoding and road tags.
package traffic_pkg;

    // Light colour codes driven onto each road's signal head.
    typedef enum logic [1:0] {
        LtGreen  = 2'd0,
        LtYellow = 2'd1,
        LtRed    = 2'd2
    } light_t;

    // Phase codes, also exported on o_phase.
    typedef enum logic [2:0] {
        PhAGrn = 3'd0,
        PhAYel = 3'd1,
        PhAAr  = 3'd2,
        PhBGrn = 3'd3,
        PhBYel = 3'd4,
        PhBAr  = 3'd5,
        PhWalk = 3'd6,
        PhEmg  = 3'd7
    } phase_t;

    // Which road receives green once a pedestrian walk completes.
    typedef enum logic {
        RoadA = 1'b0,
        RoadB = 1'b1
    } road_t;

    // Road A colour for a phase; every phase not owned by road A shows red.
    function automatic light_t light_a(phase_t ph);
        light_t lt;
        lt = LtRed;
        if (ph == PhAGrn) lt = LtGreen;
        if (ph == PhAYel) lt = LtYellow;
        return lt;
    endfunction

    // Road B colour for a phase; every phase not owned by road B shows red.
    function automatic light_t light_b(phase_t ph);
        light_t lt;
        lt = LtRed;
        if (ph == PhBGrn) lt = LtGreen;
        if (ph == PhBYel) lt = LtYellow;
        return lt;
    endfunction

endpackage

// File: rtl/traffic_phase_timer.sv
// Phase timer: counts cycles spent in the current phase, clears synchronously
// and saturates at its all-ones value instead of wrapping.
module traffic_phase_timer #(
    parameter int unsigned CNTW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    output logic [CNTW-1:0] count
);

    localparam logic [CNTW-1:0] CountMax = '1;
    localparam logic [CNTW-1:0] CountOne = {{(CNTW-1){1'b0}}, 1'b1};

    logic [CNTW-1:0] count_q;
    logic [CNTW-1:0] count_d;

    // Next count: clear wins, otherwise increment until saturated.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (count_q != CountMax) begin
            count_d = count_q + CountOne;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/traffic_phase_sched.sv
// Timed phase scheduler for a two-road intersection with a pedestrian crossing
// and emergency override. Greens obey min/max timing against opposing demand,
// yellow and all-red clearances are fixed, and all outputs are Moore decodes.
module traffic_phase_sched
    import traffic_pkg::*;
#(
    parameter int unsigned GREEN_MIN = 4,
    parameter int unsigned GREEN_MAX = 12,
    parameter int unsigned YELLOW_T  = 2,
    parameter int unsigned ALLRED_T  = 1,
    parameter int unsigned WALK_T    = 3,
    parameter int unsigned CNTW      = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_TA,
    input  logic            i_TB,
    input  logic            i_ped_req,
    input  logic            i_emg,
    output logic [1:0]      o_LA,
    output logic [1:0]      o_LB,
    output logic            o_walk,
    output logic            o_ped_ack,
    output logic [2:0]      o_phase,
    output logic [CNTW-1:0] o_timer
);

    // Timer values on which each timed phase makes its final cycle.
    localparam logic [CNTW-1:0] GminLast = CNTW'(GREEN_MIN - 1);
    localparam logic [CNTW-1:0] GmaxLast = CNTW'(GREEN_MAX - 1);
    localparam logic [CNTW-1:0] YelLast  = CNTW'(YELLOW_T - 1);
    localparam logic [CNTW-1:0] ArLast   = CNTW'(ALLRED_T - 1);
    localparam logic [CNTW-1:0] WalkLast = CNTW'(WALK_T - 1);

    phase_t          phase_q;
    phase_t          phase_d;
    logic            ped_pend_q;
    logic            ped_pend_d;
    road_t           after_walk_q;
    road_t           after_walk_d;
    logic [CNTW-1:0] timer;
    logic            phase_chg;
    logic            walk_entry;
    logic            emg_in_walk;
    logic            a_wait;
    logic            b_wait;

    // Someone other than the green road is waiting to be served.
    assign a_wait = i_TB | ped_pend_q;
    assign b_wait = i_TA | ped_pend_q;

    assign phase_chg   = (phase_d != phase_q);
    assign walk_entry  = (phase_d == PhWalk) && (phase_q != PhWalk);
    assign emg_in_walk = (phase_q == PhWalk) && i_emg;

    traffic_phase_timer #(
        .CNTW (CNTW)
    ) u_timer (
        .clk   (i_clk),
        .rst   (i_rst),
        .clr   (phase_chg),
        .count (timer)
    );

    // Next-phase selection and the post-walk road choice.
    always_comb begin
        phase_d      = phase_q;
        after_walk_d = after_walk_q;
        unique case (phase_q)
            PhAGrn: begin
                if (i_emg) begin
                    phase_d = PhAYel;
                end else if (a_wait && ((timer >= GminLast && !i_TA) || timer >= GmaxLast)) begin
                    phase_d = PhAYel;
                end
            end
            PhAYel: begin
                if (timer == YelLast) phase_d = PhAAr;
            end
            PhAAr: begin
                if (timer == ArLast) begin
                    if (i_emg) begin
                        phase_d = PhEmg;
                    end else if (ped_pend_q) begin
                        phase_d      = PhWalk;
                        after_walk_d = RoadB;
                    end else begin
                        phase_d = PhBGrn;
                    end
                end
            end
            PhBGrn: begin
                if (i_emg) begin
                    phase_d = PhBYel;
                end else if (b_wait && ((timer >= GminLast && !i_TB) || timer >= GmaxLast)) begin
                    phase_d = PhBYel;
                end
            end
            PhBYel: begin
                if (timer == YelLast) phase_d = PhBAr;
            end
            PhBAr: begin
                if (timer == ArLast) begin
                    if (i_emg) begin
                        phase_d = PhEmg;
                    end else if (ped_pend_q) begin
                        phase_d      = PhWalk;
                        after_walk_d = RoadA;
                    end else begin
                        phase_d = PhAGrn;
                    end
                end
            end
            PhWalk: begin
                // Roads are already red, so an emergency cuts the walk short.
                if (i_emg) begin
                    phase_d = PhEmg;
                end else if (timer == WalkLast) begin
                    phase_d = (after_walk_q == RoadA) ? PhAGrn : PhBGrn;
                end
            end
            PhEmg: begin
                // Recovery always goes through a full B all-red into A green.
                if (!i_emg) phase_d = PhBAr;
            end
        endcase
    end

    // Pending pedestrian request: new requests win over the walk-entry clear,
    // and a walk cut short by an emergency is re-queued.
    always_comb begin
        ped_pend_d = (ped_pend_q & ~walk_entry) | i_ped_req | emg_in_walk;
    end

    // State registers with synchronous reset; pending requests are dropped.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            phase_q      <= PhBAr;
            ped_pend_q   <= 1'b0;
            after_walk_q <= RoadB;
        end else begin
            phase_q      <= phase_d;
            ped_pend_q   <= ped_pend_d;
            after_walk_q <= after_walk_d;
        end
    end

    // Moore output decode from the registered phase and timer.
    always_comb begin
        o_LA      = light_a(phase_q);
        o_LB      = light_b(phase_q);
        o_walk    = (phase_q == PhWalk);
        o_ped_ack = (phase_q == PhWalk) && (timer == '0);
        o_phase   = phase_q;
        o_timer   = timer;
    end

endmodule

// File: tb/tb_traffic_phase_sched.sv
// Directed bench for traffic_phase_sched: per-scenario tasks compare every
// cycle's phase, lights, walk, ack and timer against hand-built phase sequences.
module tb_traffic_phase_sched;
    import traffic_pkg::*;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_TA;
    logic       i_TB;
    logic       i_ped_req;
    logic       i_emg;
    logic [1:0] o_LA;
    logic [1:0] o_LB;
    logic       o_walk;
    logic       o_ped_ack;
    logic [2:0] o_phase;
    logic [3:0] o_timer;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    int exp_q[$];

    traffic_phase_sched #(
        .GREEN_MIN (4),
        .GREEN_MAX (12),
        .YELLOW_T  (2),
        .ALLRED_T  (1),
        .WALK_T    (3),
        .CNTW      (4)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_TA      (i_TA),
        .i_TB      (i_TB),
        .i_ped_req (i_ped_req),
        .i_emg     (i_emg),
        .o_LA      (o_LA),
        .o_LB      (o_LB),
        .o_walk    (o_walk),
        .o_ped_ack (o_ped_ack),
        .o_phase   (o_phase),
        .o_timer   (o_timer)
    );

    always #5 i_clk = ~i_clk;

    // Safety: never two non-red roads, never walk unless both roads red.
    always @(negedge i_clk) begin
        if (mon_en) begin
            checks++;
            if ((o_LA !== 2'd2 && o_LB !== 2'd2) ||
                (o_walk === 1'b1 && (o_LA !== 2'd2 || o_LB !== 2'd2))) begin
                errors++;
                $display("FAIL safety: LA=%0d LB=%0d walk=%0b, required a red road and walk only with both red",
                         o_LA, o_LB, o_walk);
            end
        end
    end

    // Expected colours: 0 green, 1 yellow, 2 red.
    function automatic logic [1:0] exp_la(int ph);
        if (ph == 0) return 2'd0;
        if (ph == 1) return 2'd1;
        return 2'd2;
    endfunction

    function automatic logic [1:0] exp_lb(int ph);
        if (ph == 3) return 2'd0;
        if (ph == 4) return 2'd1;
        return 2'd2;
    endfunction

    task automatic push_seg(int ph, int n);
        repeat (n) exp_q.push_back(ph);
    endtask

    // Hold reset for a few cycles; returns at the negedge where reset drops,
    // so the DUT is showing its reset state for one more cycle.
    task automatic apply_reset();
        i_rst     = 1'b1;
        i_TA      = 1'b0;
        i_TB      = 1'b0;
        i_ped_req = 1'b0;
        i_emg     = 1'b0;
        repeat (3) @(negedge i_clk);
        i_rst  = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_reset();
        logic [12:0] want, got;
        int ph, prev, t;
        apply_reset();
        checks++;
        if (o_phase !== 3'd5) begin
            errors++;
            $display("FAIL reset_phase: got %0d required 5", o_phase);
        end
        checks++;
        if (o_LA !== 2'd2 || o_LB !== 2'd2) begin
            errors++;
            $display("FAIL reset_lights: got LA=%0d LB=%0d required 2 2", o_LA, o_LB);
        end
        checks++;
        if (o_walk !== 1'b0 || o_ped_ack !== 1'b0 || o_timer !== 4'd0) begin
            errors++;
            $display("FAIL reset_misc: got walk=%0b ack=%0b timer=%0d required 0 0 0",
                     o_walk, o_ped_ack, o_timer);
        end
        exp_q = {};
        push_seg(0, 45);
        prev = 5;
        t = 0;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge i_clk);
            ph = exp_q[k];
            t = (ph == prev) ? ((t < 15) ? t + 1 : 15) : 0;
            want = {ph[2:0], exp_la(ph), exp_lb(ph), ph == 6, ph == 6 && prev != 6, t[3:0]};
            got = {o_phase, o_LA, o_LB, o_walk, o_ped_ack, o_timer};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL idle_hold[%0d]: got %h required %h", k, got, want);
            end
            prev = ph;
        end
    endtask

    task automatic test_b_demand();
        logic [12:0] want, got;
        int ph, prev, t;
        apply_reset();
        i_TB = 1'b1;
        exp_q = {};
        push_seg(0, 4); push_seg(1, 2); push_seg(2, 1); push_seg(3, 3);
        prev = 5;
        t = 0;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge i_clk);
            ph = exp_q[k];
            t = (ph == prev) ? ((t < 15) ? t + 1 : 15) : 0;
            want = {ph[2:0], exp_la(ph), exp_lb(ph), ph == 6, ph == 6 && prev != 6, t[3:0]};
            got = {o_phase, o_LA, o_LB, o_walk, o_ped_ack, o_timer};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL b_demand[%0d]: got %h required %h", k, got, want);
            end
            prev = ph;
        end
    endtask

    task automatic test_green_max();
        logic [12:0] want, got;
        int ph, prev, t;
        apply_reset();
        i_TA = 1'b1;
        i_TB = 1'b1;
        exp_q = {};
        push_seg(0, 12); push_seg(1, 2); push_seg(2, 1);
        push_seg(3, 12); push_seg(4, 2); push_seg(5, 1);
        push_seg(0, 12); push_seg(1, 1);
        prev = 5;
        t = 0;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge i_clk);
            ph = exp_q[k];
            t = (ph == prev) ? ((t < 15) ? t + 1 : 15) : 0;
            want = {ph[2:0], exp_la(ph), exp_lb(ph), ph == 6, ph == 6 && prev != 6, t[3:0]};
            got = {o_phase, o_LA, o_LB, o_walk, o_ped_ack, o_timer};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL green_max[%0d]: got %h required %h", k, got, want);
            end
            prev = ph;
        end
    endtask

    task automatic test_ped_walk();
        logic [12:0] want, got;
        int ph, prev, t;
        apply_reset();
        exp_q = {};
        push_seg(0, 4); push_seg(1, 2); push_seg(2, 1); push_seg(6, 3); push_seg(3, 3);
        prev = 5;
        t = 0;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge i_clk);
            ph = exp_q[k];
            t = (ph == prev) ? ((t < 15) ? t + 1 : 15) : 0;
            want = {ph[2:0], exp_la(ph), exp_lb(ph), ph == 6, ph == 6 && prev != 6, t[3:0]};
            got = {o_phase, o_LA, o_LB, o_walk, o_ped_ack, o_timer};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL ped_walk[%0d]: got %h required %h", k, got, want);
            end
            prev = ph;
            i_ped_req = (k == 1);
        end
    endtask

    task automatic test_emergency();
        logic [12:0] want, got;
        int ph, prev, t;
        apply_reset();
        exp_q = {};
        push_seg(0, 2); push_seg(1, 2); push_seg(2, 1); push_seg(7, 7);
        push_seg(5, 1); push_seg(0, 3);
        prev = 5;
        t = 0;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge i_clk);
            ph = exp_q[k];
            t = (ph == prev) ? ((t < 15) ? t + 1 : 15) : 0;
            want = {ph[2:0], exp_la(ph), exp_lb(ph), ph == 6, ph == 6 && prev != 6, t[3:0]};
            got = {o_phase, o_LA, o_LB, o_walk, o_ped_ack, o_timer};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL emergency[%0d]: got %h required %h", k, got, want);
            end
            prev = ph;
            i_emg = (k >= 1 && k <= 10);
        end
    endtask

    task automatic test_emg_in_walk();
        logic [12:0] want, got;
        int ph, prev, t;
        apply_reset();
        exp_q = {};
        push_seg(0, 4); push_seg(1, 2); push_seg(2, 1); push_seg(6, 1); push_seg(7, 3);
        push_seg(5, 1); push_seg(6, 3); push_seg(0, 3);
        prev = 5;
        t = 0;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge i_clk);
            ph = exp_q[k];
            t = (ph == prev) ? ((t < 15) ? t + 1 : 15) : 0;
            want = {ph[2:0], exp_la(ph), exp_lb(ph), ph == 6, ph == 6 && prev != 6, t[3:0]};
            got = {o_phase, o_LA, o_LB, o_walk, o_ped_ack, o_timer};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL emg_in_walk[%0d]: got %h required %h", k, got, want);
            end
            prev = ph;
            i_ped_req = (k == 0);
            i_emg     = (k >= 7 && k <= 9);
        end
    endtask

    task automatic test_reset_mid_walk();
        logic [12:0] want, got;
        int ph, prev, t;
        apply_reset();
        exp_q = {};
        push_seg(0, 4); push_seg(1, 2); push_seg(2, 1); push_seg(6, 2);
        prev = 5;
        t = 0;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge i_clk);
            ph = exp_q[k];
            t = (ph == prev) ? ((t < 15) ? t + 1 : 15) : 0;
            want = {ph[2:0], exp_la(ph), exp_lb(ph), ph == 6, ph == 6 && prev != 6, t[3:0]};
            got = {o_phase, o_LA, o_LB, o_walk, o_ped_ack, o_timer};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL rst_walk_pre[%0d]: got %h required %h", k, got, want);
            end
            prev = ph;
            i_ped_req = (k == 0);
            i_rst     = (k == 8);
        end
        @(negedge i_clk);
        got = {o_phase, o_LA, o_LB, o_walk, o_ped_ack, o_timer};
        checks++;
        if (got !== {3'd5, 2'd2, 2'd2, 1'b0, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL rst_walk_state: got %h required %h", got,
                     {3'd5, 2'd2, 2'd2, 1'b0, 1'b0, 4'd0});
        end
        i_rst = 1'b0;
        // A surviving request would force A green out after 4 cycles.
        exp_q = {};
        push_seg(0, 6);
        prev = 5;
        t = 0;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge i_clk);
            ph = exp_q[k];
            t = (ph == prev) ? ((t < 15) ? t + 1 : 15) : 0;
            want = {ph[2:0], exp_la(ph), exp_lb(ph), ph == 6, ph == 6 && prev != 6, t[3:0]};
            got = {o_phase, o_LA, o_LB, o_walk, o_ped_ack, o_timer};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL rst_walk_post[%0d]: got %h required %h", k, got, want);
            end
            prev = ph;
        end
    endtask

    initial begin
        i_rst     = 1'b1;
        i_TA      = 1'b0;
        i_TB      = 1'b0;
        i_ped_req = 1'b0;
        i_emg     = 1'b0;
        test_reset();
        test_b_demand();
        test_green_max();
        test_ped_walk();
        test_emergency();
        test_emg_in_walk();
        test_reset_mid_walk();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
